// File: rtl/bitstream_power_sched.sv
// rtl/bitstream_power_sched.sv - round-robin time-sharing of one bitstream power unit
// Optional abort on request drop: define POWER_SCHED_ABORT_EN.
module bitstream_power_sched #(
  parameter int N_REQ = 4,
  parameter int EXP   = 8,
  parameter int LEN_W = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ-1:0]           i_x_in,
  output logic [N_REQ-1:0]           o_grant,
  output logic                       o_busy,
  output logic                       o_pu_x,
  input  logic                       i_pu_y,
  output logic                       o_done,
  output logic [$clog2(N_REQ)-1:0]   o_done_id,
  output logic [LEN_W:0]             o_result
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int LEN   = 1 << LEN_W;
  localparam int CNT_W = (LEN_W > $clog2(EXP)) ? LEN_W : $clog2(EXP);
  localparam logic [N_REQ-1:0] GRANT_ONE = N_REQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RUN, S_DONE} state_t;

  state_t             r_state;
  logic [N_REQ-1:0]   r_grant;
  logic [ID_W-1:0]    r_gid;
  logic [ID_W-1:0]    r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [LEN_W:0]     r_acc;
  logic               r_done;
  logic [ID_W-1:0]    r_done_id;
  logic [LEN_W:0]     r_result;

  logic               w_hit;
  logic [ID_W-1:0]    w_win;
  logic [ID_W-1:0]    w_idx;
  logic [ID_W-1:0]    w_next_ptr;
  logic               w_active;
  logic               w_abort;

  // first requesting index found when scanning upward from the pointer, wrapping
  always_comb begin
    w_hit = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = ID_W'((int'(r_ptr) + i) % N_REQ);
      if (!w_hit && i_req[w_idx]) begin
        w_hit = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_next_ptr = (r_gid == ID_W'(N_REQ - 1)) ? '0 : r_gid + 1'b1;
  assign w_active   = (r_state == S_FLUSH) || (r_state == S_RUN);

`ifdef POWER_SCHED_ABORT_EN
  assign w_abort = w_active && !i_req[r_gid];
`else
  assign w_abort = 1'b0;
`endif

  // window sequencing: grant, flush the unit's taps, count ones, report
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_gid     <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_done    <= 1'b0;
      r_done_id <= '0;
      r_result  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_state <= S_FLUSH;
            r_grant <= GRANT_ONE << w_win;
            r_gid   <= w_win;
            r_cnt   <= '0;
            r_acc   <= '0;
          end
        end
        S_FLUSH: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_ptr   <= w_next_ptr;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_W'(EXP - 1)) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_ptr   <= w_next_ptr;
            r_cnt   <= '0;
          end else begin
            r_acc <= r_acc + {{LEN_W{1'b0}}, i_pu_y};
            if (r_cnt == CNT_W'(LEN - 1)) begin
              r_state <= S_DONE;
              r_grant <= '0;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_done    <= 1'b1;
          r_done_id <= r_gid;
          r_result  <= r_acc;
          r_ptr     <= w_next_ptr;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_grant   = r_grant;
  assign o_busy    = (r_state != S_IDLE);
  assign o_pu_x    = w_active && i_x_in[r_gid];
  assign o_done    = r_done;
  assign o_done_id = r_done_id;
  assign o_result  = r_result;

endmodule

// File: tb/tb_bitstream_power_sched.sv
// tb/tb_bitstream_power_sched.sv - scoreboard bench for bitstream_power_sched
module tb_bitstream_power_sched;

  localparam int N_REQ = 4;
  localparam int EXP   = 8;
  localparam int LEN_W = 4;

  typedef struct {
    int id;
    int res;
    int cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_REQ-1:0] req = '0;
  logic [N_REQ-1:0] x_in = '0;
  logic [N_REQ-1:0] grant;
  logic             busy;
  logic             pu_x;
  logic             pu_y;
  logic             done;
  logic [1:0]       done_id;
  logic [LEN_W:0]   result;
  logic [EXP-2:0]   taps;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   multi = 0;
  int   zrun = 0;
  bit   prev_zero = 1'b1;
  bit   chk_gap = 1'b0;
  bit   gap_armed = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  bitstream_power_sched #(.N_REQ(N_REQ), .EXP(EXP), .LEN_W(LEN_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_x_in(x_in),
    .o_grant(grant), .o_busy(busy), .o_pu_x(pu_x), .i_pu_y(pu_y),
    .o_done(done), .o_done_id(done_id), .o_result(result)
  );

  // power unit: y = x AND its EXP-1 previous samples, one registered cycle
  always @(posedge clk) begin
    if (rst) begin
      taps <= '0;
      pu_y <= 1'b0;
    end else begin
      pu_y <= pu_x & (&taps);
      taps <= {taps[EXP-3:0], pu_x};
    end
  end

  task automatic check(input string name, input int act, input int exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // monitor: pop and compare on every done pulse; watch grant shape
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("done_id", int'(done_id), mon_e.id);
        check("result", int'(result), mon_e.res);
        check("done_cycle", cyc, mon_e.cyc);
      end
      n_done++;
    end
    if ($countones(grant) > 1) multi++;
    if (grant == '0) begin
      zrun++;
      prev_zero = 1'b1;
    end else begin
      if (prev_zero && chk_gap) begin
        if (gap_armed) check("idle_gap", zrun, 2);
        gap_armed = 1'b1;
      end
      zrun = 0;
      prev_zero = 1'b0;
    end
  end

  task automatic run_single(input int mode, input int exp_res);
    int c;
    int base;
    c = cyc;
    base = n_done;
    sb.push_back('{2, exp_res, c + 26});
    req = 4'b0100;
    for (int r = 0; r < 40; r++) begin
      step();
      if (n_done > base) break;
      if (r == 0) begin
        check("single_grant", int'(grant), 4'b0100);
        check("single_busy", int'(busy), 1);
      end
      case (mode)
        0: x_in[2] = 1'b1;
        1: x_in[2] = 1'b0;
        2: x_in[2] = (r % 2 == 0);
        default: x_in[2] = (r != 12);
      endcase
    end
    check("single_timeout", n_done - base, 1);
    req = '0;
    step();
  endtask

  initial begin
    int c;
    int base;
    int target;

    // reset with random inputs
    rst = 1'b1;
    repeat (2) begin
      req  = 4'($urandom);
      x_in = 4'($urandom);
      step();
    end
    check("rst_grant", int'(grant), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_done_id", int'(done_id), 0);
    rst = 1'b0;
    req = '0;
    x_in = '0;
    repeat (3) step();

    // fairness: all requesting, expect 0,1,2,3,0 every 26 cycles
    x_in = 4'hF;
    c = cyc;
    base = n_done;
    sb.push_back('{0, 16, c + 26});
    sb.push_back('{1, 16, c + 52});
    sb.push_back('{2, 16, c + 78});
    sb.push_back('{3, 16, c + 104});
    sb.push_back('{0, 16, c + 130});
    gap_armed = 1'b0;
    chk_gap = 1'b1;
    req = 4'hF;
    for (int i = 0; i < 200; i++) begin
      step();
      if (n_done >= base + 5) break;
    end
    req = '0;
    chk_gap = 1'b0;
    check("fair_timeout", n_done - base, 5);
    repeat (3) step();

    // data patterns on requester 2
    run_single(0, 16);
    run_single(1, 0);
    run_single(2, 0);
    run_single(3, 8);

    // requester 1 drops its request at RUN cycle 5 while 2 waits; pointer is 3
    x_in = 4'hF;
    c = cyc;
    base = n_done;
`ifdef POWER_SCHED_ABORT_EN
    sb.push_back('{2, 16, c + 14 + 27});
    target = base + 1;
`else
    sb.push_back('{1, 16, c + 26});
    sb.push_back('{2, 16, c + 52});
    target = base + 2;
`endif
    req = 4'b0110;
    for (int r = 0; r < 80; r++) begin
      step();
      if (n_done >= target) break;
      if (r == 0) check("abort_first_grant", int'(grant), 4'b0010);
      if (r == 13) req = 4'b0100;
`ifdef POWER_SCHED_ABORT_EN
      if (r == 14) check("abort_grant_drop", int'(grant), 0);
      if (r == 15) check("abort_next_grant", int'(grant), 4'b0100);
`else
      if (r == 14) check("noabort_grant_hold", int'(grant), 4'b0010);
      if (r == 15) check("noabort_grant_hold2", int'(grant), 4'b0010);
`endif
    end
    check("abort_timeout", n_done - base, target - base);
    req = '0;
    repeat (3) step();

    // reset at RUN cycle 10 of requester 0's window
    c = cyc;
    req = 4'b0001;
    for (int r = 0; r < 18; r++) step();
    rst = 1'b1;
    req = '0;
    step();
    check("midrst_grant", int'(grant), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_result", int'(result), 0);
    check("midrst_done", int'(done), 0);
    rst = 1'b0;
    // 1 and 3 both ask: a reset pointer picks 1, a stale pointer (3) would pick 3
    base = n_done;
    c = cyc;
    sb.push_back('{1, 16, c + 26});
    req = 4'b1010;
    step();
    check("postrst_grant", int'(grant), 4'b0010);
    for (int i = 0; i < 40; i++) begin
      if (n_done > base) break;
      step();
    end
    req = '0;
    check("postrst_timeout", n_done - base, 1);
    repeat (4) step();

    check("sb_empty", sb.size(), 0);
    check("grant_onehot", multi, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
